// File: rtl/lcd_in_timing_detect_if.sv
// Video input / timing result bundle for lcd_in_timing_detect.
// line_err exists only when LCD_TIMING_LINE_CHK_EN is defined.
interface lcd_in_timing_detect_if;
    logic        lcd_de_i;
    logic        lcd_hs_i;
    logic        lcd_vs_i;
    logic [10:0] lcd_in_h_disp;
    logic [10:0] lcd_in_v_disp;
    logic        timing_valid;
    logic        timing_change;
    logic        frame_start;
`ifdef LCD_TIMING_LINE_CHK_EN
    logic        line_err;

    modport master (
        output lcd_de_i, lcd_hs_i, lcd_vs_i,
        input  lcd_in_h_disp, lcd_in_v_disp, timing_valid, timing_change, frame_start, line_err
    );
    modport slave (
        input  lcd_de_i, lcd_hs_i, lcd_vs_i,
        output lcd_in_h_disp, lcd_in_v_disp, timing_valid, timing_change, frame_start, line_err
    );
`else
    modport master (
        output lcd_de_i, lcd_hs_i, lcd_vs_i,
        input  lcd_in_h_disp, lcd_in_v_disp, timing_valid, timing_change, frame_start
    );
    modport slave (
        input  lcd_de_i, lcd_hs_i, lcd_vs_i,
        output lcd_in_h_disp, lcd_in_v_disp, timing_valid, timing_change, frame_start
    );
`endif
endinterface

// File: rtl/lcd_in_timing_detect.sv
// Measures active width/height of the LCD input stream and publishes a debounced resolution.
// Optional per-line width check (adds line_err): LCD_TIMING_LINE_CHK_EN.
//
// state   | meaning
// IDLE    | waiting for the first frame start; the partial first frame is never measured
// MEASURE | collecting candidates until STABLE_FRAMES identical good frames are seen
// LOCKED  | outputs valid; mismatching/bad frames counted toward LOST_FRAMES
module lcd_in_timing_detect #(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned LOST_FRAMES   = 2,
    parameter logic [23:0] TIMEOUT_CYC   = 24'd4000000,
    parameter logic        VS_POL        = 1'b1,
    parameter logic        DE_POL        = 1'b1
) (
    input logic                   lcd_pclk_i,
    input logic                   rst_n,
    lcd_in_timing_detect_if.slave video
);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    localparam logic [3:0]  STABLE_N = 4'(STABLE_FRAMES);
    localparam logic [3:0]  LOST_N   = 4'(LOST_FRAMES);
    localparam logic [10:0] CNT_MAX  = 11'h7ff;

    logic        s1_de, s1_vs, s1_hs, s2_de, s2_vs, s2_hs;
    logic        de_pin, vs_pin;
    logic        fs_det, de_fall, line_end, first_line;
    logic        hcnt_sat, vcnt_sat, line_mis, bad_nxt;
    logic [10:0] hcnt, vcnt, line_w;
    logic [10:0] hcnt_p1, line_w_nxt, vcnt_nxt;
    logic        frame_bad, skip_line;
    logic [10:0] cand_w, cand_v;
    logic        cand_bad;
    logic [23:0] tocnt;
    logic        timeout;
    state_t      state;
    logic [3:0]  match_cnt, miss_cnt, match_nxt, miss_nxt;
    logic [10:0] prev_w, prev_v, h_disp, v_disp;
    logic        cand_same_prev, cand_same_out;
    logic        timing_valid, timing_change, frame_start;

    assign de_pin = (video.lcd_de_i == DE_POL);
    assign vs_pin = (video.lcd_vs_i == VS_POL);

    always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
        if (!rst_n) begin
            s1_de <= 1'b0;
            s1_vs <= 1'b0;
            s1_hs <= 1'b0;
            s2_de <= 1'b0;
            s2_vs <= 1'b0;
            s2_hs <= 1'b0;
        end else begin
            s1_de <= de_pin;
            s1_vs <= vs_pin;
            s1_hs <= video.lcd_hs_i;
            s2_de <= s1_de;
            s2_vs <= s1_vs;
            s2_hs <= s1_hs;
        end
    end

    // hsync is monitored only; it takes no part in measurement
    logic unused_hs;
    assign unused_hs = s1_hs ^ s2_hs;

    assign fs_det     = s1_vs & ~s2_vs;
    assign de_fall    = s2_de & ~s1_de;
    assign line_end   = de_fall & ~skip_line;
    assign first_line = (vcnt == 11'd0);
    assign hcnt_sat   = (hcnt == CNT_MAX);
    assign vcnt_sat   = (vcnt == CNT_MAX);
    assign hcnt_p1    = hcnt_sat ? CNT_MAX : hcnt + 11'd1;
    assign line_w_nxt = (line_end && first_line) ? hcnt_p1 : line_w;
    assign vcnt_nxt   = (line_end && !vcnt_sat) ? vcnt + 11'd1 : vcnt;

`ifdef LCD_TIMING_LINE_CHK_EN
    assign line_mis = line_end & ~first_line & (hcnt_p1 != line_w);
`else
    assign line_mis = 1'b0;
`endif

    assign bad_nxt = frame_bad | hcnt_sat | (line_end & vcnt_sat) | line_mis;

    // A line ending in the frame-start cycle is folded into the candidate before evaluation
    always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
        if (!rst_n) begin
            hcnt      <= '0;
            vcnt      <= '0;
            line_w    <= '0;
            frame_bad <= 1'b0;
            skip_line <= 1'b0;
            cand_w    <= '0;
            cand_v    <= '0;
            cand_bad  <= 1'b0;
        end else if (fs_det) begin
            cand_w    <= line_w_nxt;
            cand_v    <= vcnt_nxt;
            cand_bad  <= bad_nxt | s1_de | (line_w_nxt == 11'd0) | (vcnt_nxt == 11'd0);
            hcnt      <= '0;
            vcnt      <= '0;
            line_w    <= '0;
            frame_bad <= 1'b0;
            skip_line <= s1_de;
        end else begin
            frame_bad <= bad_nxt;
            line_w    <= line_w_nxt;
            vcnt      <= vcnt_nxt;
            if (de_fall) begin
                hcnt      <= '0;
                skip_line <= 1'b0;
            end else if (s1_de && s2_de && !skip_line && !hcnt_sat) begin
                hcnt <= hcnt + 11'd1;
            end
        end
    end

`ifdef LCD_TIMING_LINE_CHK_EN
    logic line_err;
    always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
        if (!rst_n) line_err <= 1'b0;
        else        line_err <= line_mis;
    end
    assign video.line_err = line_err;
`endif

    assign timeout = (tocnt == TIMEOUT_CYC);

    always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
        if (!rst_n)        tocnt <= '0;
        else if (fs_det)   tocnt <= '0;
        else if (!timeout) tocnt <= tocnt + 24'd1;
    end

    assign cand_same_prev = (cand_w == prev_w) && (cand_v == prev_v);
    assign cand_same_out  = !cand_bad && (cand_w == h_disp) && (cand_v == v_disp);
    assign match_nxt      = cand_same_prev ? match_cnt + 4'd1 : 4'd1;
    assign miss_nxt       = miss_cnt + 4'd1;

    always_ff @(posedge lcd_pclk_i or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            prev_w        <= '0;
            prev_v        <= '0;
            h_disp        <= '0;
            v_disp        <= '0;
            timing_valid  <= 1'b0;
            timing_change <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            timing_change <= 1'b0;
            frame_start   <= fs_det;
            if (timeout) begin
                timing_change <= timing_valid;
                h_disp        <= '0;
                v_disp        <= '0;
                timing_valid  <= 1'b0;
                match_cnt     <= '0;
                miss_cnt      <= '0;
                state         <= IDLE;
            end else if (frame_start) begin
                case (state)
                    IDLE: begin
                        match_cnt <= '0;
                        state     <= MEASURE;
                    end
                    MEASURE: begin
                        if (cand_bad) begin
                            match_cnt <= '0;
                        end else begin
                            if (!cand_same_prev) begin
                                prev_w <= cand_w;
                                prev_v <= cand_v;
                            end
                            if (match_nxt == STABLE_N) begin
                                h_disp        <= cand_w;
                                v_disp        <= cand_v;
                                timing_valid  <= 1'b1;
                                timing_change <= 1'b1;
                                match_cnt     <= '0;
                                miss_cnt      <= '0;
                                state         <= LOCKED;
                            end else begin
                                match_cnt <= match_nxt;
                            end
                        end
                    end
                    LOCKED: begin
                        if (cand_same_out) begin
                            miss_cnt <= '0;
                        end else if (miss_nxt == LOST_N) begin
                            h_disp        <= '0;
                            v_disp        <= '0;
                            timing_valid  <= 1'b0;
                            timing_change <= 1'b1;
                            match_cnt     <= '0;
                            miss_cnt      <= '0;
                            state         <= MEASURE;
                        end else begin
                            miss_cnt <= miss_nxt;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign video.lcd_in_h_disp = h_disp;
    assign video.lcd_in_v_disp = v_disp;
    assign video.timing_valid  = timing_valid;
    assign video.timing_change = timing_change;
    assign video.frame_start   = frame_start;
endmodule
